exe_result_buf: RTL and testbench

//  Downstream stage of the execute-unit adder: registers add/sub/slt/sltu results into a 2-entry

---
 rtl/exe_result_buf.sv | 160 ++++++++++++++++
 tb/tb_exe_result_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_result_buf.sv
// rtl/exe_result_buf.sv - 2-entry execute result buffer with precise overflow exception
//
// Purpose:
//   Registers add/sub/slt/sltu results from the execute-unit adder into a
//   2-entry circular FIFO and hands them to the memory stage over a
//   valid/ready handshake. A trapping overflow becomes a precise exception:
//   the faulting entry keeps its result but loses write-back, and all
//   younger inputs are accepted and dropped until a flush arrives.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous flush, empties buffer, highest priority
//   in_valid   in   1      execute stage presents a result
//   in_ready   out  1      buffer accepts this cycle
//   in_res     in   BUS    adder result
//   in_ovf     in   1      adder overflow flag
//   in_trap    in   1      overflow traps for this instruction
//   in_wen     in   1      instruction writes a register
//   in_dest    in   REG_W  destination register index
//   out_valid  out  1      head entry valid
//   out_ready  in   1      memory stage accepts head
//   out_res    out  BUS    head result (0 when out_valid=0)
//   out_wen    out  1      head write enable (0 when out_valid=0)
//   out_dest   out  REG_W  head destination (0 when out_valid=0)
//   out_exc    out  1      head carries overflow exception (0 when out_valid=0)
//   blocked    out  1      exception in flight, younger inputs discarded

module exe_result_buf #(
    parameter int BUS   = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS-1:0]   in_res,
    input  logic             in_ovf,
    input  logic             in_trap,
    input  logic             in_wen,
    input  logic [REG_W-1:0] in_dest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS-1:0]   out_res,
    output logic             out_wen,
    output logic [REG_W-1:0] out_dest,
    output logic             out_exc,
    output logic             blocked
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLOCK = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [BUS-1:0]   res_q  [2];
    logic [BUS-1:0]   res_d  [2];
    logic [REG_W-1:0] dest_q [2];
    logic [REG_W-1:0] dest_d [2];
    logic [1:0]       wen_q, wen_d;
    logic [1:0]       exc_q, exc_d;
    logic [1:0]       vld_q, vld_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;

    logic in_exc;
    logic do_push;
    logic do_store;
    logic do_pop;
    logic store_wen;

    assign in_exc    = in_ovf & in_trap;
    // A faulting entry never writes back; writes to register 0 are also suppressed.
    assign store_wen = in_wen & ~in_exc & (in_dest != '0);

    assign blocked   = (state_q == ST_BLOCK);
    // Depends only on registered state so it never combinationally follows out_ready.
    assign in_ready  = (count_q != 2'd2) | blocked;

    assign out_valid = vld_q[rd_ptr_q];
    assign out_res   = out_valid ? res_q[rd_ptr_q]  : '0;
    assign out_dest  = out_valid ? dest_q[rd_ptr_q] : '0;
    assign out_wen   = out_valid & wen_q[rd_ptr_q];
    assign out_exc   = out_valid & exc_q[rd_ptr_q];

    assign do_push   = in_valid & in_ready;
    // While blocked, pushes complete the handshake but are thrown away.
    assign do_store  = do_push & (state_q == ST_RUN);
    assign do_pop    = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        dest_d   = dest_q;
        wen_d    = wen_q;
        exc_d    = exc_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            state_d  = ST_RUN;
            vld_d    = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ~rd_ptr_q;
            end
            // With count==1 the pop and store slots differ, so both may apply.
            if (do_store) begin
                vld_d[wr_ptr_q]  = 1'b1;
                res_d[wr_ptr_q]  = in_res;
                dest_d[wr_ptr_q] = in_dest;
                wen_d[wr_ptr_q]  = store_wen;
                exc_d[wr_ptr_q]  = in_exc;
                wr_ptr_d         = ~wr_ptr_q;
            end
            count_d = count_q + {1'b0, do_store} - {1'b0, do_pop};

            case (state_q)
                ST_RUN:   if (do_store && in_exc) state_d = ST_BLOCK;
                ST_BLOCK: state_d = ST_BLOCK;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            res_q    <= '{default: '0};
            dest_q   <= '{default: '0};
            wen_q    <= '0;
            exc_q    <= '0;
            vld_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            dest_q   <= dest_d;
            wen_q    <= wen_d;
            exc_q    <= exc_d;
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_exe_result_buf.sv
// tb/tb_exe_result_buf.sv - scoreboard bench for exe_result_buf

module tb_exe_result_buf;

    localparam int BUS   = 32;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [BUS-1:0]   res;
        logic             wen;
        logic [REG_W-1:0] dest;
        logic             exc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [BUS-1:0]   in_res;
    logic             in_ovf;
    logic             in_trap;
    logic             in_wen;
    logic [REG_W-1:0] in_dest;
    logic             out_valid;
    logic             out_ready;
    logic [BUS-1:0]   out_res;
    logic             out_wen;
    logic [REG_W-1:0] out_dest;
    logic             out_exc;
    logic             blocked;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    exe_result_buf #(.BUS(BUS), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
        .in_ovf(in_ovf), .in_trap(in_trap), .in_wen(in_wen), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_wen(out_wen), .out_dest(out_dest), .out_exc(out_exc),
        .blocked(blocked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: every accepted head is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_res", out_res, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_res",  out_res,  e.res);
                check("out_wen",  {31'd0, out_wen},  {31'd0, e.wen});
                check("out_dest", {27'd0, out_dest}, {27'd0, e.dest});
                check("out_exc",  {31'd0, out_exc},  {31'd0, e.exc});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. Holds the request until in_ready is seen, then
    // records the hand-computed expectation if the entry should be stored.
    task automatic push(input logic [BUS-1:0] res, input logic ovf, input logic trap,
                        input logic wen, input logic [REG_W-1:0] dest,
                        input logic stored, input logic exp_wen, input logic exp_exc);
        bit got;
        exp_t e;
        in_valid = 1'b1; in_res = res; in_ovf = ovf; in_trap = trap;
        in_wen = wen; in_dest = dest;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) check("push_timeout_in_ready", {31'd0, in_ready}, 32'd1);
        if (got && stored) begin
            e.res = res; e.wen = exp_wen; e.dest = dest; e.exc = exp_exc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_res = '0;
        in_ovf = 1'b0; in_trap = 1'b0; in_wen = 1'b0; in_dest = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_blocked",   {31'd0, blocked},   32'd0);
        check("rst_out_res",   out_res, 32'd0);
        check("rst_out_wen",   {31'd0, out_wen},   32'd0);
        check("rst_out_dest",  {27'd0, out_dest},  32'd0);
        check("rst_out_exc",   {31'd0, out_exc},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Single add, one-cycle latency.
        out_ready = 1'b1;
        push(32'h5, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_out_res",   out_res, 32'h5);
        cyc(); cyc();
        check("t1_drained",   {31'd0, out_valid}, 32'd0);

        // Backpressure: buffer fills, then drains in order.
        out_ready = 1'b0;
        push(32'hA, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
        push(32'hB, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t2_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("t2_full_head",     out_res, 32'hA);
        cyc();
        out_ready = 1'b1;
        cyc(); cyc(); cyc();
        check("t2_drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back with draining: push and pop together at count 1.
        push(32'hC, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        push(32'hD, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
        push(32'hE, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t2b_in_ready", {31'd0, in_ready}, 32'd1);
        cyc(); cyc();

        // Overflow trap: exception entry, younger push dropped, flush recovers.
        push(32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t3_blocked", {31'd0, blocked}, 32'd1);
        cyc();
        push(32'h7, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        check("t3_dropped_no_out", {31'd0, out_valid}, 32'd0);
        check("t3_still_blocked",  {31'd0, blocked},   32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t3_unblocked", {31'd0, blocked}, 32'd0);

        // Non-trapping overflow passes through normally.
        push(32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t4_blocked", {31'd0, blocked}, 32'd0);
        cyc(); cyc();

        // Flush with count 2, BLOCK state and a concurrent push.
        out_ready = 1'b0;
        push(32'h1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        push(32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_blocked",  {31'd0, blocked},  32'd1);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        flush = 1'b1; in_valid = 1'b1; in_res = 32'h33; in_dest = 5'd11;
        sb.delete();
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_in_ready2", {31'd0, in_ready},  32'd1);
        check("t5_blocked2",  {31'd0, blocked},   32'd0);
        cyc();

        // dest 0 suppresses write-back.
        out_ready = 1'b1;
        push(32'h42, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc(); cyc();

        // Async reset mid-stream.
        out_ready = 1'b0;
        push(32'h9, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        check("t6_pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_async_rst_res",   out_res, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc();

        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
